// File: rtl/inst_encoder.sv
// RISC-V instruction word encoder with a 2-entry output FIFO.
// Requests are packed and range-checked in the cycle they are accepted.
module inst_encoder #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enc_valid,
  output logic                 enc_ready,
  input  logic [2:0]           fmt,
  input  logic [6:0]           opcode,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic [31:0]          imm,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [31:0]          inst,
  output logic                 inst_err,
  output logic [CNT_WIDTH-1:0] inst_count
);

  typedef struct packed {
    logic        err;
    logic [31:0] word;
  } ent_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic f_r, f_i, f_s, f_b, f_u, f_j;
  logic fits12, fits13, fits21;
  logic [31:0] enc_word;
  logic        enc_err;

  assign f_r = (fmt == 3'd0);
  assign f_i = (fmt == 3'd1);
  assign f_s = (fmt == 3'd2);
  assign f_b = (fmt == 3'd3);
  assign f_u = (fmt == 3'd4);
  assign f_j = (fmt == 3'd5);

  // Signed fit: all bits above the field's sign bit must match it.
  assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    enc_word = NOP;
    enc_err  = 1'b1;
    unique case (1'b1)
      f_r: begin
        enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
        enc_err  = 1'b0;
      end
      f_i: begin
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err  = ~fits12;
      end
      f_s: begin
        enc_word = {imm[11:5], rs2, rs1, funct3,
                    imm[4:0], opcode};
        enc_err  = ~fits12;
      end
      f_b: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3,
                    imm[4:1], imm[11], opcode};
        enc_err  = ~fits13 | imm[0];
      end
      f_u: begin
        enc_word = {imm[31:12], rd, opcode};
        enc_err  = |imm[11:0];
      end
      f_j: begin
        enc_word = {imm[20], imm[10:1], imm[11],
                    imm[19:12], rd, opcode};
        enc_err  = ~fits21 | imm[0];
      end
      default: begin
        enc_word = NOP;
        enc_err  = 1'b1;
      end
    endcase
  end

  ent_t                 mem_q [2];
  ent_t                 mem_d [2];
  logic [1:0]           occ_q, occ_d;
  logic                 head_q, head_d;
  logic                 tail_q, tail_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 push, pop;

  assign enc_ready  = (occ_q != 2'd2);
  assign inst_valid = (occ_q != 2'd0);
  assign push       = enc_valid & enc_ready;
  assign pop        = inst_valid & inst_ready;

  // Gate the head so nothing stale shows while the FIFO is empty.
  assign inst       = inst_valid ? mem_q[head_q].word : 32'd0;
  assign inst_err   = inst_valid & mem_q[head_q].err;
  assign inst_count = cnt_q;

  always_comb begin
    mem_d  = mem_q;
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (push) begin
      mem_d[tail_q] = '{err: enc_err, word: enc_word};
      tail_d        = ~tail_q;
    end
    if (pop) begin
      head_d = ~head_q;
      cnt_d  = cnt_q + CNT_WIDTH'(1);
    end
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      occ_q    <= 2'd0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      occ_q    <= occ_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16: width of the emitted-instruction counter.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port enc_valid, input, 1: an encode request is present.
REQ-005 SHALL have port enc_ready, output, 1: the block can accept a request this cycle.
REQ-006 SHALL have port fmt, input, 3: instruction format (0 R, 1 I, 2 S, 3 B, 4 U, 5 J; 6-7 illegal).
REQ-007 SHALL have ports opcode (7), rd (5), rs1 (5), rs2 (5), funct3 (3) and funct7 (7), all inputs: instruction fields.
REQ-008 SHALL have port imm, input, 32: signed immediate byte value (U-type: the full 32-bit upper value).
REQ-009 SHALL have port inst_valid, output, 1: an encoded word is available at the head.
REQ-010 SHALL have port inst_ready, input, 1: the consumer takes the head word.
REQ-011 SHALL have port inst, output, 32: the encoded head word.
REQ-012 SHALL have port inst_err, output, 1: the head word's immediate was not representable or its fmt was illegal.
REQ-013 SHALL have port inst_count, output, CNT_WIDTH: the number of words popped, wrapping modulo 2^CNT_WIDTH.

Function
REQ-014 SHALL accept a request when enc_valid && enc_ready, and pop the head when inst_valid && inst_ready.
REQ-015 SHALL encode each accepted request combinationally and write {inst, err} into a 2-entry in-order FIFO in the same cycle, so the word is visible on inst one cycle after acceptance.
REQ-016 SHALL drive enc_ready = (occupancy < 2), registered-state only, with no combinational path from inst_ready.
REQ-017 SHALL drive inst_valid = (occupancy != 0); inst and inst_err SHALL hold stable while inst_valid && !inst_ready.
REQ-018 SHALL handle push and pop in the same cycle at occupancy 1 by leaving occupancy at 1 and advancing the head; at occupancy 2 no push can occur.
REQ-019 SHALL pack R-type as {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-020 SHALL pack I-type as {imm[11:0], rs1, funct3, rd, opcode}.
REQ-021 SHALL pack S-type as {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-022 SHALL pack B-type as {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-023 SHALL pack U-type as {imm[31:12], rd, opcode}.
REQ-024 SHALL pack J-type as {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-025 SHALL set err=1 on any of: I/S imm outside [-2048, 2047]; B imm outside [-4096, 4094] or odd; J imm outside [-2^20, 2^20-2] or odd; U imm[11:0] != 0.
REQ-026 SHALL still emit the truncated packing when err=1 and the fmt is legal.
REQ-027 SHALL, for fmt 6-7, emit inst = 32'h00000013 with err=1.
REQ-028 SHALL increment inst_count by 1 per pop, wrapping from all-ones to 0.

Reset
REQ-029 SHALL, on rst_n low at any time including mid-transfer, immediately clear occupancy, head and tail pointers, and inst_count.
REQ-030 SHALL hold inst_valid=0, inst=0, inst_err=0, inst_count=0 and enc_ready=1 while rst_n is low; FIFO contents are discarded.
REQ-031 SHALL accept requests from the first rising clk edge after rst_n deasserts.

Verification
REQ-032 I-type fmt=1, opcode=0x13, rd=1, rs1=0, funct3=0, imm=5 -> next cycle inst=0x00500093, inst_err=0; U-type fmt=4, opcode=0x37, rd=5, imm=0x12345000 -> inst=0x123452B7.
REQ-033 S-type fmt=2, opcode=0x23, funct3=2, rs1=1, rs2=2, imm=8 -> inst=0x0020A423; B-type fmt=3, opcode=0x63, rs1=rs2=0, funct3=0, imm=-4 -> inst=0xFE000EE3, err=0.
REQ-034 I-type imm=2048, rd=1, opcode=0x13 -> inst=0x80000093, inst_err=1; B-type imm=6 -> err=0; imm=3 -> err=1; fmt=7 -> inst=0x00000013, err=1.
REQ-035 inst_ready=0 with 3 back-to-back requests -> enc_ready drops after 2 accepts and the third request is held; raising inst_ready -> three words pop in order, inst_count=3.
REQ-036 Continuous enc_valid and inst_ready for 70000 requests -> one word per cycle after the first, and inst_count wraps to 70000-65536=4464.
REQ-037 Occupancy 2 and rst_n pulsed low between clock edges -> inst_valid=0, inst_count=0 and enc_ready=1 immediately, and no stale word appears after release.
